// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory among N_REQ cores.
// Registered grant/memory strobes, 2-stage read-return tracking, saturating contention counter.
module dm_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 8,
    parameter int WDATA_W = 16,
    parameter int RDATA_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arb_en,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           we,
    input  logic [N_REQ*ADDR_W-1:0]    addr,
    input  logic [N_REQ*WDATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           rvalid,
    output logic [RDATA_W-1:0]         rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [WDATA_W-1:0]         mem_wdata,
    input  logic [RDATA_W-1:0]         mem_rdata,
    output logic [CNT_W-1:0]           contention_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   rvalid_q, rvalid_d;
    logic [RDATA_W-1:0] rdata_q, rdata_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [WDATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   last_q, last_d;
    logic               s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [PTR_W-1:0]   s1_id_q, s1_id_d, s2_id_q, s2_id_d;

    logic [N_REQ-1:0]   elig;
    logic               found;
    logic [PTR_W-1:0]   win;
    int unsigned        n_elig;
    int unsigned        idx;

    always_comb begin
        // The core granted this cycle still has req high; mask it to avoid a double grant.
        elig   = req & ~gnt_q;
        found  = 1'b0;
        win    = '0;
        n_elig = 0;
        idx    = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (!found && elig[PTR_W'(idx)]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            n_elig = n_elig + int'(elig[i]);
        end

        gnt_d       = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        last_d      = last_q;
        s1_vld_d    = 1'b0;
        s1_id_d     = s1_id_q;
        s2_vld_d    = s1_vld_q;
        s2_id_d     = s1_id_q;
        rvalid_d    = '0;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;

        if (arb_en && found) begin
            gnt_d[win]  = 1'b1;
            mem_en_d    = 1'b1;
            mem_we_d    = we[win];
            mem_addr_d  = addr[int'(win)*ADDR_W +: ADDR_W];
            mem_wdata_d = wdata[int'(win)*WDATA_W +: WDATA_W];
            last_d      = win;
            s1_vld_d    = ~we[win];
            s1_id_d     = win;
        end

        // Stage 2 lines up with the cycle in which the memory drives read data.
        if (s2_vld_q) begin
            rvalid_d[s2_id_q] = 1'b1;
            rdata_d           = mem_rdata;
        end

        if (arb_en && (n_elig >= 2) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
            last_q      <= PTR_W'(N_REQ - 1);
            s1_vld_q    <= 1'b0;
            s1_id_q     <= '0;
            s2_vld_q    <= 1'b0;
            s2_id_q     <= '0;
        end else begin
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            s1_vld_q    <= s1_vld_d;
            s1_id_q     <= s1_id_d;
            s2_vld_q    <= s2_vld_d;
            s2_id_q     <= s2_id_d;
        end
    end

    assign gnt            = gnt_q;
    assign rvalid         = rvalid_q;
    assign rdata          = rdata_q;
    assign mem_en         = mem_en_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed, table-driven bench for dm_port_arbiter plus hand sequences for
// overlapping reads, arb_en gating, mid-flight reset and counter saturation.
`timescale 1ns/1ps
module tb_dm_port_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         arb_en = 1'b1;
    logic [3:0]   req = '0;
    logic [3:0]   we = '0;
    logic [31:0]  addr = '0;
    logic [63:0]  wdata = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    logic [3:0]   gnt, rvalid;
    logic [7:0]   rdata, mem_addr, mem_rdata;
    logic         mem_en, mem_we;
    logic [15:0]  mem_wdata, contention_cnt;

    int n_total = 0;
    int n_pass  = 0;

    dm_port_arbiter #(.N_REQ(N), .ADDR_W(8), .WDATA_W(16), .RDATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .contention_cnt(contention_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    typedef struct {
        bit          pre_rst;
        logic        en;
        logic [3:0]  req;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [7:0]  mrd;
        logic [3:0]  e_gnt;
        logic        e_men;
        logic        e_mwe;
        logic [7:0]  e_maddr;
        logic [15:0] e_mwd;
        logic [3:0]  e_rv;
        logic [7:0]  e_rd;
        logic [15:0] e_cnt;
    } vec_t;

    localparam logic [31:0] A1 = 32'h0000_0010;
    localparam logic [31:0] A2 = 32'h0302_0100;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
        // test 1: single read; test 2: rotation with writes; test 3: pointer after core 2
        tbl.push_back('{1, 1, 4'b0001, 4'b0000, A1, 8'h00, 4'b0001, 1, 0, 8'h10, 16'hA000, 4'b0000, 8'h00, 16'd0});
        tbl.push_back('{0, 1, 4'b0000, 4'b0000, A1, 8'h5A, 4'b0000, 0, 0, 8'h10, 16'hA000, 4'b0000, 8'h00, 16'd0});
        tbl.push_back('{0, 1, 4'b0000, 4'b0000, A1, 8'hA5, 4'b0000, 0, 0, 8'h10, 16'hA000, 4'b0001, 8'hA5, 16'd0});
        tbl.push_back('{0, 1, 4'b0000, 4'b0000, A1, 8'h00, 4'b0000, 0, 0, 8'h10, 16'hA000, 4'b0000, 8'h00, 16'd0});
        tbl.push_back('{1, 1, 4'b1111, 4'b1111, A2, 8'h00, 4'b0001, 1, 1, 8'h00, 16'hA000, 4'b0000, 8'h00, 16'd1});
        tbl.push_back('{0, 1, 4'b1111, 4'b1111, A2, 8'h00, 4'b0010, 1, 1, 8'h01, 16'hA001, 4'b0000, 8'h00, 16'd2});
        tbl.push_back('{0, 1, 4'b1111, 4'b1111, A2, 8'h00, 4'b0100, 1, 1, 8'h02, 16'hA002, 4'b0000, 8'h00, 16'd3});
        tbl.push_back('{0, 1, 4'b1111, 4'b1111, A2, 8'h00, 4'b1000, 1, 1, 8'h03, 16'hA003, 4'b0000, 8'h00, 16'd4});
        tbl.push_back('{0, 1, 4'b1111, 4'b1111, A2, 8'h00, 4'b0001, 1, 1, 8'h00, 16'hA000, 4'b0000, 8'h00, 16'd5});
        tbl.push_back('{1, 1, 4'b0100, 4'b1111, A2, 8'h00, 4'b0100, 1, 1, 8'h02, 16'hA002, 4'b0000, 8'h00, 16'd0});
        tbl.push_back('{0, 1, 4'b1011, 4'b1111, A2, 8'h00, 4'b1000, 1, 1, 8'h03, 16'hA003, 4'b0000, 8'h00, 16'd1});
        tbl.push_back('{0, 1, 4'b1011, 4'b1111, A2, 8'h00, 4'b0001, 1, 1, 8'h00, 16'hA000, 4'b0000, 8'h00, 16'd2});
        tbl.push_back('{0, 1, 4'b1011, 4'b1111, A2, 8'h00, 4'b0010, 1, 1, 8'h01, 16'hA001, 4'b0000, 8'h00, 16'd3});
        tbl.push_back('{0, 1, 4'b0000, 4'b1111, A2, 8'h00, 4'b0000, 0, 0, 8'h01, 16'hA001, 4'b0000, 8'h00, 16'd3});

        mem_rdata = '0;
        do_reset();
        chk("rst.gnt",    32'(gnt), 0);
        chk("rst.rvalid", 32'(rvalid), 0);
        chk("rst.rdata",  32'(rdata), 0);
        chk("rst.mem_en", 32'({mem_en, mem_we}), 0);
        chk("rst.maddr",  32'(mem_addr), 0);
        chk("rst.mwdata", 32'(mem_wdata), 0);
        chk("rst.cnt",    32'(contention_cnt), 0);

        foreach (tbl[i]) begin
            if (tbl[i].pre_rst) do_reset();
            arb_en = tbl[i].en; req = tbl[i].req; we = tbl[i].we;
            addr = tbl[i].addr; mem_rdata = tbl[i].mrd;
            step();
            chk($sformatf("v%0d.gnt", i),    32'(gnt),       32'(tbl[i].e_gnt));
            chk($sformatf("v%0d.mem_en", i), 32'(mem_en),    32'(tbl[i].e_men));
            chk($sformatf("v%0d.mem_we", i), 32'(mem_we),    32'(tbl[i].e_mwe));
            chk($sformatf("v%0d.maddr", i),  32'(mem_addr),  32'(tbl[i].e_maddr));
            chk($sformatf("v%0d.mwdata", i), 32'(mem_wdata), 32'(tbl[i].e_mwd));
            chk($sformatf("v%0d.rvalid", i), 32'(rvalid),    32'(tbl[i].e_rv));
            if (tbl[i].e_rv != 0) chk($sformatf("v%0d.rdata", i), 32'(rdata), 32'(tbl[i].e_rd));
            chk($sformatf("v%0d.cnt", i),    32'(contention_cnt), 32'(tbl[i].e_cnt));
        end

        // overlapping reads: core 1 then core 3
        do_reset();
        addr = 32'h4000_2000; we = 4'b0000; arb_en = 1'b1;
        req = 4'b1010; mem_rdata = 8'h00;
        step();
        chk("ovl.gnt1",  32'(gnt), 32'b0010);
        chk("ovl.addr1", 32'(mem_addr), 32'h20);
        req = 4'b1000;
        step();
        chk("ovl.gnt3",  32'(gnt), 32'b1000);
        chk("ovl.addr3", 32'(mem_addr), 32'h40);
        chk("ovl.cnt",   32'(contention_cnt), 1);
        req = 4'b0000; mem_rdata = 8'h11;
        step();
        chk("ovl.rv1", 32'(rvalid), 32'b0010);
        chk("ovl.rd1", 32'(rdata), 32'h11);
        mem_rdata = 8'h33;
        step();
        chk("ovl.rv3", 32'(rvalid), 32'b1000);
        chk("ovl.rd3", 32'(rdata), 32'h33);
        mem_rdata = 8'h00;
        step();
        chk("ovl.rv_end", 32'(rvalid), 0);

        // arb_en dropped after a read grant
        do_reset();
        addr = A2; we = 4'b0000; req = 4'b0001; arb_en = 1'b1;
        step();
        chk("en.gnt0", 32'(gnt), 32'b0001);
        arb_en = 1'b0; req = 4'b0110; mem_rdata = 8'h00;
        step();
        chk("en.nogntA", 32'(gnt), 0);
        chk("en.memoff", 32'(mem_en), 0);
        mem_rdata = 8'h77;
        step();
        chk("en.rv",     32'(rvalid), 32'b0001);
        chk("en.rd",     32'(rdata), 32'h77);
        chk("en.nogntB", 32'(gnt), 0);
        chk("en.cnt",    32'(contention_cnt), 0);
        step();
        chk("en.nogntC", 32'(gnt), 0);
        arb_en = 1'b1;
        step();
        chk("en.resume", 32'(gnt), 32'b0010);
        chk("en.cnt1",   32'(contention_cnt), 1);
        req = 4'b0100;
        step();
        chk("en.next",   32'(gnt), 32'b0100);

        // reset pulsed while a read grant is on the memory port
        do_reset();
        addr = A2; we = 4'b0000; req = 4'b0100; arb_en = 1'b1;
        step();
        chk("mr.pre_gnt", 32'(gnt), 32'b0100);
        rst_n = 1'b0;
        #2;
        chk("mr.gnt",   32'(gnt), 0);
        chk("mr.men",   32'({mem_en, mem_we}), 0);
        chk("mr.maddr", 32'(mem_addr), 0);
        chk("mr.rv",    32'(rvalid), 0);
        req = 4'b0000; mem_rdata = 8'hEE;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("mr.norv%0d", k), 32'(rvalid), 0);
        end
        req = 4'b1100;
        step();
        chk("mr.first", 32'(gnt), 32'b0100);

        // saturation: every edge contended with all four cores requesting
        do_reset();
        addr = A2; we = 4'b1111; req = 4'b1111; arb_en = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("sat.fffe", 32'(contention_cnt), 32'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("sat.ffff", 32'(contention_cnt), 32'hFFFF);
        req = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
